// File: rtl/instruction_fetch_if.sv
// Memory read bus and instruction-register load bus of the fetch sequencer.
// The master modport is the fetch side; the slave modport is memory plus instruction register.
interface instruction_fetch_if #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 8
);
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_rd;
  logic [DATA_W-1:0] mem_data;
  logic              mem_valid;
  logic [DATA_W-1:0] ir_data;
  logic              ir_ena;
  logic              ir_ack;

  modport master (
    output mem_addr, mem_rd, ir_data, ir_ena,
    input  mem_data, mem_valid, ir_ack
  );

  modport slave (
    input  mem_addr, mem_rd, ir_data, ir_ena,
    output mem_data, mem_valid, ir_ack
  );
endinterface

// File: rtl/instruction_fetch.sv
// Fetch sequencer: reads program memory at pc and holds each word on the instruction-register
// load bus until acknowledged. Supports jump redirect, graceful halt and an ack timeout.
module instruction_fetch #(
  parameter int ADDR_W      = 4,
  parameter int RESET_PC    = 0,
  parameter int ACK_TIMEOUT = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              halt,
  input  logic              jmp_en,
  input  logic [ADDR_W-1:0] jmp_addr,
  instruction_fetch_if.master bus,
  output logic [ADDR_W-1:0] pc,
  output logic              busy,
  output logic              fetch_done,
  output logic              err
);

  localparam int DATA_W = 8;
  localparam int CNT_W  = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(ACK_TIMEOUT - 1);
  localparam logic [ADDR_W-1:0] PC_INIT  = ADDR_W'(RESET_PC);

  typedef enum logic [2:0] {
    IDLE,
    REQ,
    WAIT_MEM,
    WAIT_ACK,
    ERROR
  } state_t;

  state_t            state;
  state_t            state_nxt;
  logic [CNT_W-1:0]  ack_cnt;
  logic              jmp_pend;
  logic [ADDR_W-1:0] jmp_tgt;
  logic              halt_pend;
  logic [DATA_W-1:0] ir_data_q;

  logic mem_take;
  logic ack_take;
  logic ack_expire;
  logic stop_after;
  logic mem_rd_c;
  logic ir_ena_c;
  logic busy_c;

  // A jump arriving together with the ack wins over an older pending one.
  function automatic logic [ADDR_W-1:0] advance_pc(
    input logic [ADDR_W-1:0] cur,
    input logic              jmp_now,
    input logic [ADDR_W-1:0] jmp_now_addr,
    input logic              pend,
    input logic [ADDR_W-1:0] pend_addr
  );
    if (jmp_now)
      return jmp_now_addr;
    if (pend)
      return pend_addr;
    return cur + ADDR_W'(1);
  endfunction

  assign mem_take   = (state == WAIT_MEM) && bus.mem_valid;
  assign ack_take   = (state == WAIT_ACK) && bus.ir_ack;
  assign ack_expire = (state == WAIT_ACK) && !bus.ir_ack && (ack_cnt == CNT_LAST);
  assign stop_after = halt_pend || halt;

  always_comb begin
    state_nxt = state;
    mem_rd_c  = 1'b0;
    ir_ena_c  = 1'b0;
    busy_c    = 1'b0;
    case (state)
      IDLE: begin
        if (start && !halt)
          state_nxt = REQ;
      end
      REQ: begin
        mem_rd_c  = 1'b1;
        busy_c    = 1'b1;
        state_nxt = WAIT_MEM;
      end
      WAIT_MEM: begin
        busy_c = 1'b1;
        if (bus.mem_valid)
          state_nxt = WAIT_ACK;
      end
      WAIT_ACK: begin
        ir_ena_c = 1'b1;
        busy_c   = 1'b1;
        if (ack_take)
          state_nxt = stop_after ? IDLE : REQ;
        else if (ack_expire)
          state_nxt = ERROR;
      end
      ERROR: begin
        if (start)
          state_nxt = REQ;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      state <= IDLE;
    else
      state <= state_nxt;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc         <= PC_INIT;
      jmp_pend   <= 1'b0;
      jmp_tgt    <= '0;
      halt_pend  <= 1'b0;
      ack_cnt    <= '0;
      fetch_done <= 1'b0;
      err        <= 1'b0;
      ir_data_q  <= '0;
    end else begin
      fetch_done <= ack_take;

      if (state == IDLE && jmp_en)
        pc <= jmp_addr;
      else if (ack_take)
        pc <= advance_pc(pc, jmp_en, jmp_addr, jmp_pend, jmp_tgt);

      if (ack_take) begin
        jmp_pend <= 1'b0;
      end else if (jmp_en && state != IDLE) begin
        jmp_pend <= 1'b1;
        jmp_tgt  <= jmp_addr;
      end

      // A timed-out fetch never completes, so a halt requested during it is dropped.
      if (ack_take || ack_expire)
        halt_pend <= 1'b0;
      else if (halt && busy_c)
        halt_pend <= 1'b1;

      if (mem_take)
        ack_cnt <= '0;
      else if (state == WAIT_ACK)
        ack_cnt <= ack_cnt + CNT_W'(1);

      if (ack_expire)
        err <= 1'b1;
      else if (state == ERROR && start)
        err <= 1'b0;

      if (mem_take)
        ir_data_q <= bus.mem_data;
    end
  end

  assign bus.mem_addr = pc;
  assign bus.mem_rd   = mem_rd_c;
  assign bus.ir_ena   = ir_ena_c;
  assign bus.ir_data  = ir_data_q;
  assign busy         = busy_c;

endmodule

// File: tb/tb_instruction_fetch.sv
// Bench for instruction_fetch: a memory/instruction-register responder plus a behavioural
// expectation of the fetched address stream, data words and pc updates.
module tb_instruction_fetch;
  localparam int ADDR_W      = 4;
  localparam int ACK_TIMEOUT = 8;

  logic              clk = 1'b0;
  logic              rst;
  logic              start;
  logic              halt;
  logic              jmp_en;
  logic [ADDR_W-1:0] jmp_addr;
  logic [ADDR_W-1:0] pc;
  logic              busy;
  logic              fetch_done;
  logic              err;

  instruction_fetch_if #(.ADDR_W(ADDR_W)) bus ();

  instruction_fetch #(
    .ADDR_W(ADDR_W),
    .RESET_PC(0),
    .ACK_TIMEOUT(ACK_TIMEOUT)
  ) dut (
    .clk(clk),
    .rst(rst),
    .start(start),
    .halt(halt),
    .jmp_en(jmp_en),
    .jmp_addr(jmp_addr),
    .bus(bus),
    .pc(pc),
    .busy(busy),
    .fetch_done(fetch_done),
    .err(err)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  logic [7:0]        mem [16];
  int                mem_lat   = 1;
  int                ack_after = 2;
  bit                ack_en    = 1'b1;
  bit                spur_ack  = 1'b0;
  int                mem_pend  = 0;
  logic [ADDR_W-1:0] mem_pend_addr = '0;
  int                ena_cnt   = 0;

  // One clock: advance to the falling edge, then play memory and instruction register.
  task automatic cyc();
    @(negedge clk);
    bus.mem_valid = 1'b0;
    bus.mem_data  = 8'($urandom);
    if (mem_pend > 0) begin
      mem_pend--;
      if (mem_pend == 0) begin
        bus.mem_valid = 1'b1;
        bus.mem_data  = mem[mem_pend_addr];
      end
    end
    if (bus.mem_rd === 1'b1) begin
      mem_pend      = mem_lat;
      mem_pend_addr = bus.mem_addr;
    end
    if (bus.ir_ena === 1'b1) begin
      ena_cnt++;
      bus.ir_ack = (ack_en && (ena_cnt >= ack_after)) ? 1'b1 : 1'b0;
    end else begin
      ena_cnt    = 0;
      bus.ir_ack = spur_ack ? 1'($urandom_range(0, 1)) : 1'b0;
    end
  endtask

  task automatic wait_done(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 100; i++) begin
      cyc();
      if (fetch_done === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic jump_idle(input logic [ADDR_W-1:0] a);
    jmp_en   = 1'b1;
    jmp_addr = a;
    cyc();
    jmp_en   = 1'b0;
  endtask

  task automatic test_reset();
    int act;
    rst = 1'b0; start = 1'b0; halt = 1'b0; jmp_en = 1'b0; jmp_addr = '0;
    bus.mem_valid = 1'b0; bus.mem_data = '0; bus.ir_ack = 1'b0;
    mem_pend = 0; ena_cnt = 0;
    #2;
    checks++; if (pc !== 4'h0) begin errors++; $display("FAIL reset_pc: got %h expected 0", pc); end
    checks++; if (bus.mem_rd !== 1'b0) begin errors++; $display("FAIL reset_mem_rd: got %b expected 0", bus.mem_rd); end
    checks++; if (bus.ir_ena !== 1'b0) begin errors++; $display("FAIL reset_ir_ena: got %b expected 0", bus.ir_ena); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
    checks++; if (fetch_done !== 1'b0) begin errors++; $display("FAIL reset_fetch_done: got %b expected 0", fetch_done); end
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL reset_err: got %b expected 0", err); end
    checks++; if (bus.ir_data !== 8'h00) begin errors++; $display("FAIL reset_ir_data: got %h expected 00", bus.ir_data); end
    repeat (2) @(negedge clk);
    rst = 1'b1;
    act = 0;
    repeat (4) begin
      cyc();
      if (busy !== 1'b0 || bus.mem_rd !== 1'b0) act++;
    end
    checks++; if (act != 0) begin errors++; $display("FAIL reset_idle_activity: got %0d active cycles expected 0", act); end
  endtask

  task automatic test_sequential();
    logic [ADDR_W-1:0] exp;
    int nf, ena_n, rd;
    mem[0] = 8'hA5; mem[1] = 8'h3C; mem[2] = 8'hF0;
    mem_lat = 1; ack_after = 2; ack_en = 1'b1;
    start = 1'b1; cyc(); start = 1'b0;
    checks++; if (bus.mem_rd !== 1'b1 || bus.mem_addr !== 4'h0 || busy !== 1'b1)
      begin errors++; $display("FAIL seq_first_req: got rd=%b addr=%h busy=%b expected 1 0 1", bus.mem_rd, bus.mem_addr, busy); end
    exp = 4'h0; nf = 0; ena_n = 0;
    for (int i = 0; i < 80 && nf < 3; i++) begin
      cyc();
      halt = 1'b0;
      if (bus.ir_ena === 1'b1) begin
        ena_n++;
        checks++; if (bus.ir_data !== mem[exp]) begin errors++; $display("FAIL seq_ir_data: got %h expected %h", bus.ir_data, mem[exp]); end
      end
      if (fetch_done === 1'b1) begin
        checks++; if (bus.ir_ena !== 1'b0) begin errors++; $display("FAIL seq_ena_drop: got %b expected 0", bus.ir_ena); end
        checks++; if (ena_n != 2) begin errors++; $display("FAIL seq_ena_cycles: got %0d expected 2", ena_n); end
        checks++; if (pc !== exp + 4'h1) begin errors++; $display("FAIL seq_pc: got %h expected %h", pc, exp + 4'h1); end
        exp = exp + 4'h1; nf++; ena_n = 0;
        if (nf == 2) halt = 1'b1;
      end
    end
    checks++; if (nf != 3) begin errors++; $display("FAIL seq_done_count: got %0d expected 3", nf); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL seq_halt_busy: got %b expected 0", busy); end
    rd = 0;
    repeat (5) begin cyc(); if (bus.mem_rd === 1'b1) rd++; end
    checks++; if (rd != 0) begin errors++; $display("FAIL seq_no_more_rd: got %0d reads expected 0", rd); end
    checks++; if (pc !== 4'h3) begin errors++; $display("FAIL seq_final_pc: got %h expected 3", pc); end
  endtask

  task automatic test_wrap();
    bit ok;
    mem[15] = 8'h6E; mem[0] = 8'h81;
    jump_idle(4'hF);
    checks++; if (pc !== 4'hF) begin errors++; $display("FAIL wrap_idle_jump: got %h expected f", pc); end
    start = 1'b1; cyc(); start = 1'b0;
    halt = 1'b1; cyc(); halt = 1'b0;
    wait_done(ok);
    checks++; if (!ok) begin errors++; $display("FAIL wrap_done: got no fetch_done expected one"); end
    checks++; if (pc !== 4'h0) begin errors++; $display("FAIL wrap_pc: got %h expected 0", pc); end
    checks++; if (bus.ir_data !== 8'h6E) begin errors++; $display("FAIL wrap_ir_data: got %h expected 6e", bus.ir_data); end
    start = 1'b1; cyc(); start = 1'b0;
    checks++; if (bus.mem_rd !== 1'b1 || bus.mem_addr !== 4'h0)
      begin errors++; $display("FAIL wrap_next_rd: got rd=%b addr=%h expected 1 0", bus.mem_rd, bus.mem_addr); end
    halt = 1'b1; cyc(); halt = 1'b0;
    wait_done(ok);
    checks++; if (!ok || bus.ir_data !== 8'h81 || pc !== 4'h1)
      begin errors++; $display("FAIL wrap_second: got ok=%b data=%h pc=%h expected 1 81 1", ok, bus.ir_data, pc); end
  endtask

  task automatic test_jump();
    bit ok;
    bit seen;
    mem[2] = 8'h42; mem[9] = 8'h99;
    jump_idle(4'h2);
    mem_lat = 3;
    start = 1'b1; cyc(); start = 1'b0;
    cyc();
    jmp_en = 1'b1; jmp_addr = 4'h9; cyc(); jmp_en = 1'b0;
    mem_lat = 1;
    wait_done(ok);
    checks++; if (!ok) begin errors++; $display("FAIL jump_done: got no fetch_done expected one"); end
    checks++; if (pc !== 4'h9) begin errors++; $display("FAIL jump_pc: got %h expected 9", pc); end
    checks++; if (bus.ir_data !== 8'h42) begin errors++; $display("FAIL jump_ir_data: got %h expected 42", bus.ir_data); end
    checks++; if (bus.mem_rd !== 1'b1 || bus.mem_addr !== 4'h9)
      begin errors++; $display("FAIL jump_next_rd: got rd=%b addr=%h expected 1 9", bus.mem_rd, bus.mem_addr); end
    seen = 1'b0;
    for (int i = 0; i < 30; i++) begin
      cyc();
      if (bus.ir_ack === 1'b1) begin seen = 1'b1; break; end
    end
    jmp_en = 1'b1; jmp_addr = 4'h9; cyc(); jmp_en = 1'b0;
    checks++; if (!seen || fetch_done !== 1'b1 || pc !== 4'h9)
      begin errors++; $display("FAIL jump_with_ack: got ack=%b done=%b pc=%h expected 1 1 9", seen, fetch_done, pc); end
    checks++; if (bus.mem_rd !== 1'b1 || bus.mem_addr !== 4'h9)
      begin errors++; $display("FAIL jump_with_ack_rd: got rd=%b addr=%h expected 1 9", bus.mem_rd, bus.mem_addr); end
    halt = 1'b1; cyc(); halt = 1'b0;
    wait_done(ok);
    checks++; if (!ok || pc !== 4'hA || bus.ir_data !== 8'h99)
      begin errors++; $display("FAIL jump_after: got ok=%b pc=%h data=%h expected 1 a 99", ok, pc, bus.ir_data); end
  endtask

  task automatic test_halt();
    int ena_n, rd, dn;
    mem[5] = 8'hC3; ack_after = 4;
    jump_idle(4'h5);
    start = 1'b1; cyc(); start = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (bus.ir_ena === 1'b1) break;
      cyc();
    end
    ena_n = (bus.ir_ena === 1'b1) ? 1 : 0;
    halt = 1'b1; cyc(); halt = 1'b0;
    for (int i = 0; i < 30; i++) begin
      if (fetch_done === 1'b1) break;
      checks++; if (bus.ir_ena !== 1'b1) begin errors++; $display("FAIL halt_ena_held: got %b expected 1", bus.ir_ena); end
      ena_n++;
      cyc();
    end
    checks++; if (ena_n != 4) begin errors++; $display("FAIL halt_ena_cycles: got %0d expected 4", ena_n); end
    checks++; if (fetch_done !== 1'b1 || bus.ir_ena !== 1'b0 || busy !== 1'b0)
      begin errors++; $display("FAIL halt_stop: got done=%b ena=%b busy=%b expected 1 0 0", fetch_done, bus.ir_ena, busy); end
    checks++; if (pc !== 4'h6 || bus.ir_data !== 8'hC3)
      begin errors++; $display("FAIL halt_pc: got pc=%h data=%h expected 6 c3", pc, bus.ir_data); end
    rd = 0; dn = 0;
    repeat (6) begin
      cyc();
      if (bus.mem_rd === 1'b1) rd++;
      if (fetch_done === 1'b1) dn++;
    end
    checks++; if (rd != 0 || dn != 0) begin errors++; $display("FAIL halt_quiet: got rd=%0d done=%0d expected 0 0", rd, dn); end
    ack_after = 2;
  endtask

  task automatic test_timeout();
    bit ok;
    bit got;
    int ena_n, rd;
    mem[7] = 8'h1F; ack_en = 1'b0;
    jump_idle(4'h7);
    start = 1'b1; cyc(); start = 1'b0;
    ena_n = 0; got = 1'b0;
    for (int i = 0; i < 40; i++) begin
      cyc();
      if (bus.ir_ena === 1'b1) ena_n++;
      if (err === 1'b1) begin got = 1'b1; break; end
    end
    checks++; if (!got) begin errors++; $display("FAIL timeout_err: got err=%b expected 1", err); end
    checks++; if (ena_n != ACK_TIMEOUT) begin errors++; $display("FAIL timeout_ena_cycles: got %0d expected %0d", ena_n, ACK_TIMEOUT); end
    checks++; if (bus.ir_ena !== 1'b0 || busy !== 1'b0 || pc !== 4'h7)
      begin errors++; $display("FAIL timeout_state: got ena=%b busy=%b pc=%h expected 0 0 7", bus.ir_ena, busy, pc); end
    rd = 0;
    repeat (3) begin cyc(); if (bus.mem_rd === 1'b1) rd++; end
    checks++; if (err !== 1'b1 || rd != 0) begin errors++; $display("FAIL timeout_sticky: got err=%b rd=%0d expected 1 0", err, rd); end
    ack_en = 1'b1;
    start = 1'b1; cyc(); start = 1'b0;
    checks++; if (err !== 1'b0 || bus.mem_rd !== 1'b1 || bus.mem_addr !== 4'h7)
      begin errors++; $display("FAIL timeout_restart: got err=%b rd=%b addr=%h expected 0 1 7", err, bus.mem_rd, bus.mem_addr); end
    halt = 1'b1; cyc(); halt = 1'b0;
    wait_done(ok);
    checks++; if (!ok || bus.ir_data !== 8'h1F || pc !== 4'h8)
      begin errors++; $display("FAIL timeout_refetch: got ok=%b data=%h pc=%h expected 1 1f 8", ok, bus.ir_data, pc); end
  endtask

  task automatic test_reset_mid();
    int act;
    mem[3] = 8'h5A; ack_after = 6;
    jump_idle(4'h3);
    start = 1'b1; cyc(); start = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (bus.ir_ena === 1'b1) break;
      cyc();
    end
    checks++; if (bus.ir_ena !== 1'b1 || bus.ir_data !== 8'h5A)
      begin errors++; $display("FAIL rstmid_pre: got ena=%b data=%h expected 1 5a", bus.ir_ena, bus.ir_data); end
    #2 rst = 1'b0;
    #1;
    checks++; if (bus.ir_ena !== 1'b0 || pc !== 4'h0 || bus.ir_data !== 8'h00 || busy !== 1'b0)
      begin errors++; $display("FAIL rstmid_async: got ena=%b pc=%h data=%h busy=%b expected 0 0 00 0", bus.ir_ena, pc, bus.ir_data, busy); end
    @(negedge clk);
    rst = 1'b1; mem_pend = 0; ena_cnt = 0; bus.ir_ack = 1'b0; ack_after = 2;
    act = 0;
    repeat (5) begin
      cyc();
      if (busy !== 1'b0 || bus.mem_rd !== 1'b0) act++;
    end
    checks++; if (act != 0 || pc !== 4'h0) begin errors++; $display("FAIL rstmid_idle: got active=%0d pc=%h expected 0 0", act, pc); end
  endtask

  task automatic test_random();
    bit ok;
    logic [ADDR_W-1:0] exp, nxt, t;
    int j1, j2;
    for (int i = 0; i < 16; i++) mem[i] = 8'($urandom);
    spur_ack = 1'b1;
    exp = 4'($urandom);
    jump_idle(exp);
    mem_lat = $urandom_range(1, 4);
    start = 1'b1; cyc(); start = 1'b0;
    for (int f = 0; f < 40; f++) begin
      checks++; if (bus.mem_rd !== 1'b1 || bus.mem_addr !== exp)
        begin errors++; $display("FAIL rnd_addr: got rd=%b addr=%h expected 1 %h", bus.mem_rd, bus.mem_addr, exp); end
      ack_after = $urandom_range(2, 5);
      mem_lat   = $urandom_range(1, 4);
      j1 = $urandom_range(0, 3);
      j2 = $urandom_range(0, 3);
      nxt = exp + 4'h1;
      for (int d = 1; d <= 3; d++) begin
        if (d == j1 || d == j2) begin
          t = 4'($urandom);
          jmp_en = 1'b1; jmp_addr = t; nxt = t;
        end
        if (f == 39 && d == 1) halt = 1'b1;
        cyc();
        jmp_en = 1'b0; halt = 1'b0;
      end
      wait_done(ok);
      checks++; if (!ok) begin errors++; $display("FAIL rnd_done: got no fetch_done expected one at fetch %0d", f); break; end
      checks++; if (bus.ir_data !== mem[exp]) begin errors++; $display("FAIL rnd_ir_data: got %h expected %h", bus.ir_data, mem[exp]); end
      checks++; if (pc !== nxt) begin errors++; $display("FAIL rnd_pc: got %h expected %h", pc, nxt); end
      exp = nxt;
    end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rnd_halt_busy: got %b expected 0", busy); end
    spur_ack = 1'b0;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_sequential();
    test_wrap();
    test_jump();
    test_halt();
    test_timeout();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
